// File: rtl/rids_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rids_pkg
//  Description : Shared RIDS definitions (sizes, NULL rule ID, typedefs) and
//                slot helper functions used across the RIDS datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package rids_pkg;

    localparam int NUM_RID    = 8;
    localparam int RID_WIDTH  = 4;
    localparam int RIDS_WIDTH = NUM_RID * RID_WIDTH;
    // Slot index wide enough to also hold NUM_RID, meaning "no further slot".
    localparam int IDX_WIDTH  = $clog2(NUM_RID) + 1;

    typedef logic [RID_WIDTH-1:0]  rid_t;
    typedef logic [RIDS_WIDTH-1:0] rids_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;

    localparam rid_t NULL_RID = {RID_WIDTH{1'b1}};

    // Slot lookup; an out-of-range index reads as NULL_RID.
    function automatic rid_t rid_slot(input rids_t w, input idx_t idx);
        rid_t r;
        r = NULL_RID;
        for (int j = 0; j < NUM_RID; j++) begin
            if (idx == idx_t'(j)) begin
                r = w[j*RID_WIDTH +: RID_WIDTH];
            end
        end
        return r;
    endfunction

    // Index of the first slot after idx whose value differs from slot idx,
    // or NUM_RID when every remaining slot repeats it.
    function automatic idx_t next_distinct(input rids_t w, input idx_t idx);
        idx_t r;
        logic found;
        rid_t cur;
        r     = idx_t'(NUM_RID);
        found = 1'b0;
        cur   = rid_slot(w, idx);
        for (int j = 0; j < NUM_RID; j++) begin
            if (!found && (idx_t'(j) > idx) && (w[j*RID_WIDTH +: RID_WIDTH] != cur)) begin
                r     = idx_t'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Slot idx is the final beat when the next distinct value is NULL or absent.
    function automatic logic is_last(input rids_t w, input idx_t idx);
        return rid_slot(w, next_distinct(w, idx)) == NULL_RID;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rids_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rids_fifo
//  Description : Synchronous FIFO holding merged RIDS words, with occupancy
//                count and full/empty flags. DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module rids_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);

    // Storage write; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; push+pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rids_match_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : rids_match_serializer
//  Description : Buffers merged RIDS words and streams the distinct matched
//                rule IDs of each word one per beat, framed with out_last;
//                an all-NULL word yields a single out_none beat.
//                Optional feature macro RIDS_BEST_MATCH_EN adds best_valid /
//                best_rid (slot 0 of each word as it is loaded).
//  Revision    : 1.0 - initial release
// ============================================================================
module rids_match_serializer
    import rids_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RIDS_WIDTH-1:0] in_rids,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RID_WIDTH-1:0]  out_rid,
    output logic                  out_last,
    output logic                  out_none
`ifdef RIDS_BEST_MATCH_EN
    ,
    output logic                  best_valid,
    output logic [RID_WIDTH-1:0]  best_rid
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    rid_t             r_out_rid;
    logic             r_out_last;
    logic             r_out_none;
    rids_t            r_word;
    idx_t             r_idx;

    logic             w_push;
    logic             w_pop;
    logic             w_fire;
    rids_t            w_head;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_full;
    logic             w_empty;
    rid_t             w_head_rid;
    logic             w_head_last;
    idx_t             w_nxt_idx;
    logic             w_nxt_last;

    assign w_push      = in_valid && r_in_ready && !w_full;
    assign w_pop       = (r_state == S_LOAD) && !w_empty;
    assign w_fire      = r_out_valid && out_ready;
    assign w_cnt_nxt   = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head_rid  = rid_slot(w_head, idx_t'(0));
    assign w_head_last = is_last(w_head, idx_t'(0));
    assign w_nxt_idx   = next_distinct(r_word, r_idx);
    assign w_nxt_last  = is_last(r_word, w_nxt_idx);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_rid   = r_out_rid;
    assign out_last  = r_out_last;
    assign out_none  = r_out_none;

    rids_fifo #(
        .WIDTH (RIDS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (in_rids),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ready reflects next-cycle occupancy only; a same-cycle pop never lets a push through on full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_cnt_nxt < CNT_W'(FIFO_DEPTH));
        end
    end

    // Packet FSM: load a word, then step through its distinct slots on each handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_rid   <= NULL_RID;
            r_out_last  <= 1'b0;
            r_out_none  <= 1'b0;
            r_word      <= '1;
            r_idx       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // An incoming push also counts, so a lone word sees N+2 latency.
                    if (!w_empty || w_push) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!w_empty) begin
                        r_word      <= w_head;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_rid   <= w_head_rid;
                        r_out_none  <= (w_head_rid == NULL_RID);
                        r_out_last  <= w_head_last;
                        r_state     <= S_EMIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EMIT: begin
                    if (w_fire) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_none  <= 1'b0;
                            r_out_rid   <= NULL_RID;
                            r_state     <= (!w_empty || w_push) ? S_LOAD : S_IDLE;
                        end else begin
                            r_idx      <= w_nxt_idx;
                            r_out_rid  <= rid_slot(r_word, w_nxt_idx);
                            r_out_last <= w_nxt_last;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RIDS_BEST_MATCH_EN
    logic r_best_valid;
    rid_t r_best_rid;

    assign best_valid = r_best_valid;
    assign best_rid   = r_best_rid;

    // Slot 0 is the highest-priority match; pulse it once per loaded word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_best_valid <= 1'b0;
            r_best_rid   <= NULL_RID;
        end else begin
            r_best_valid <= w_pop;
            if (w_pop) begin
                r_best_rid <= w_head_rid;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rids_match_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rids_match_serializer
//  Description : Directed self-checking bench for rids_match_serializer.
//                Define RIDS_BEST_MATCH_EN to also exercise best_valid/best_rid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rids_match_serializer;

    localparam logic [3:0] F = 4'hF;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rids;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_rid;
    logic        out_last;
    logic        out_none;
`ifdef RIDS_BEST_MATCH_EN
    logic        best_valid;
    logic [3:0]  best_rid;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_b [8];

    rids_match_serializer #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rids   (in_rids),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rid   (out_rid),
        .out_last  (out_last),
        .out_none  (out_none)
`ifdef RIDS_BEST_MATCH_EN
        ,
        .best_valid (best_valid),
        .best_rid   (best_rid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk8(input logic [3:0] a, b, c, d, e, f, g, h);
        return {h, g, f, e, d, c, b, a};
    endfunction

    // Holds in_valid until the word is accepted, then drops it.
    task automatic push_word(input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_rids  = w;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("push_accept", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Expects one packet of n beats from exp_b; optional stall before beat stall_at.
    task automatic expect_pkt(input string tag, input int n, input logic none, input int stall_at);
        int w;
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                out_ready = 1'b0;
                tick();
                tick();
                chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
                chk({tag, "_hold_rid"}, {28'd0, out_rid}, {28'd0, exp_b[k]});
                out_ready = 1'b1;
            end
            chk({tag, "_rid"},  {28'd0, out_rid},  {28'd0, exp_b[k]});
            chk({tag, "_last"}, {31'd0, out_last}, {31'd0, (k == n - 1)});
            chk({tag, "_none"}, {31'd0, out_none}, {31'd0, none});
            tick();
        end
        chk({tag, "_bubble"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_rids   = '1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_rid",   {28'd0, out_rid},   32'hF);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_out_none",  {31'd0, out_none},  32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single packet, exact latency and framing.
        in_valid = 1'b1;
        in_rids  = mk8(4'd1, 4'd3, 4'd5, F, F, F, F, F);
        tick();
        in_valid = 1'b0;
        chk("t1_n1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_b0_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_b0_rid",   {28'd0, out_rid},   32'd1);
        chk("t1_b0_last",  {31'd0, out_last},  32'd0);
        chk("t1_b0_none",  {31'd0, out_none},  32'd0);
        tick();
        chk("t1_b1_rid",   {28'd0, out_rid},   32'd3);
        chk("t1_b1_last",  {31'd0, out_last},  32'd0);
        tick();
        chk("t1_b2_rid",   {28'd0, out_rid},   32'd5);
        chk("t1_b2_last",  {31'd0, out_last},  32'd1);
        tick();
        chk("t1_end_valid", {31'd0, out_valid}, 32'd0);

        // All-NULL word.
        push_word(mk8(F, F, F, F, F, F, F, F));
        exp_b = '{F, F, F, F, F, F, F, F};
        expect_pkt("t2", 1, 1'b1, -1);

        // Dedup, then a fully populated word with a mid-packet stall.
        push_word(mk8(4'd2, 4'd2, 4'd7, 4'd7, 4'd9, F, F, F));
        push_word(mk8(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7));
        exp_b = '{4'd2, 4'd7, 4'd9, F, F, F, F, F};
        expect_pkt("t3a", 3, 1'b0, -1);
        exp_b = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        expect_pkt("t3b", 8, 1'b0, 3);

        // Back-pressure: one word sits in the output stage, four fill the FIFO.
        out_ready = 1'b0;
        push_word(mk8(4'd1, F, F, F, F, F, F, F));
        push_word(mk8(4'd2, 4'd3, F, F, F, F, F, F));
        push_word(mk8(F, F, F, F, F, F, F, F));
        push_word(mk8(4'd4, 4'd4, F, F, F, F, F, F));
        push_word(mk8(4'd6, F, F, F, F, F, F, F));
        in_valid = 1'b1;
        in_rids  = mk8(4'd8, 4'd9, F, F, F, F, F, F);
        tick();
        tick();
        chk("t4_full_in_ready", {31'd0, in_ready},  32'd0);
        chk("t4_hold_valid",    {31'd0, out_valid}, 32'd1);
        chk("t4_hold_rid",      {28'd0, out_rid},   32'd1);
        chk("t4_hold_last",     {31'd0, out_last},  32'd1);
        fork
            begin
                push_word(mk8(4'd8, 4'd9, F, F, F, F, F, F));
            end
            begin
                out_ready = 1'b1;
                exp_b = '{4'd1, F, F, F, F, F, F, F};
                expect_pkt("t4a", 1, 1'b0, -1);
                exp_b = '{4'd2, 4'd3, F, F, F, F, F, F};
                expect_pkt("t4b", 2, 1'b0, -1);
                exp_b = '{F, F, F, F, F, F, F, F};
                expect_pkt("t4c", 1, 1'b1, -1);
                exp_b = '{4'd4, F, F, F, F, F, F, F};
                expect_pkt("t4d", 1, 1'b0, -1);
                exp_b = '{4'd6, F, F, F, F, F, F, F};
                expect_pkt("t4e", 1, 1'b0, -1);
                exp_b = '{4'd8, 4'd9, F, F, F, F, F, F};
                expect_pkt("t4f", 2, 1'b0, -1);
            end
        join

        // Reset mid-packet drops the packet and the queued word.
        push_word(mk8(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7));
        push_word(mk8(4'd1, F, F, F, F, F, F, F));
        tick();
        tick();
        chk("t5_mid_rid", {28'd0, out_rid}, 32'd2);
        reset = 1'b1;
        tick();
        chk("t5_rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("t5_rst_rid",      {28'd0, out_rid},   32'hF);
        chk("t5_rst_in_ready", {31'd0, in_ready},  32'd0);
        reset = 1'b0;
        tick();
        chk("t5_post_in_ready", {31'd0, in_ready},  32'd1);
        chk("t5_post_valid0",   {31'd0, out_valid}, 32'd0);
        tick();
        chk("t5_post_valid1",   {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_rids  = mk8(4'd3, F, F, F, F, F, F, F);
        tick();
        in_valid = 1'b0;
        chk("t5_n1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t5_n2_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_n2_rid",   {28'd0, out_rid},   32'd3);
        chk("t5_n2_last",  {31'd0, out_last},  32'd1);
        tick();
        chk("t5_end_valid", {31'd0, out_valid}, 32'd0);

`ifdef RIDS_BEST_MATCH_EN
        // Best-match pulse for a matched word, then for an all-NULL word.
        tick();
        in_valid = 1'b1;
        in_rids  = mk8(4'd4, 4'd6, F, F, F, F, F, F);
        tick();
        in_valid = 1'b0;
        chk("t6a_n1_best_valid", {31'd0, best_valid}, 32'd0);
        tick();
        chk("t6a_n2_best_valid", {31'd0, best_valid}, 32'd1);
        chk("t6a_n2_best_rid",   {28'd0, best_rid},   32'd4);
        tick();
        chk("t6a_n3_best_valid", {31'd0, best_valid}, 32'd0);
        chk("t6a_n3_rid",        {28'd0, out_rid},    32'd6);
        tick();
        chk("t6a_end_valid",     {31'd0, out_valid},  32'd0);
        in_valid = 1'b1;
        in_rids  = mk8(F, F, F, F, F, F, F, F);
        tick();
        in_valid = 1'b0;
        chk("t6b_n1_best_valid", {31'd0, best_valid}, 32'd0);
        tick();
        chk("t6b_n2_best_valid", {31'd0, best_valid}, 32'd1);
        chk("t6b_n2_best_rid",   {28'd0, best_rid},   32'hF);
        chk("t6b_n2_none",       {31'd0, out_none},   32'd1);
        tick();
        chk("t6b_n3_best_valid", {31'd0, best_valid}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
